// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: frame sequencer for a 4-tap parallel FIR datapath.
//
// Holds shadow and active coefficient banks. Flushes the FIR delay line with
// zeros, streams a frame of samples from a synchronous sample RAM (read
// latency 1) into the filter, and tags each valid filter output. A one-cycle
// done pulse marks frame completion.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   start_i, abort_i     frame request (honoured in idle) / cancel frame
//   frame_len_i          sample count, 1..2^ADDR_W
//   coef_we_i/sel_i/wdata_i  shadow coefficient write port
//   mem_addr_o, mem_rdata_i  sample RAM read port
//   fir_b0_o..fir_b3_o   active coefficients to the FIR
//   fir_data_in_o        registered sample to the FIR
//   fir_data_out_i       FIR result, one clock after fir_data_in_o
//   out_valid_o, out_data_o  result tag and copy of fir_data_out_i
//   busy_o, done_o       frame in progress / frame-complete pulse
//   checksum_o           (FIR_SEQ_CHECKSUM_EN only) running sum of valid outputs
//
// Optional feature macro: FIR_SEQ_CHECKSUM_EN.
module fir_seq_ctrl #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TAPS   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   frame_len_i,
  input  logic              coef_we_i,
  input  logic [1:0]        coef_sel_i,
  input  logic [7:0]        coef_wdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [N-1:0]      mem_rdata_i,
  output logic [7:0]        fir_b0_o,
  output logic [7:0]        fir_b1_o,
  output logic [7:0]        fir_b2_o,
  output logic [7:0]        fir_b3_o,
  output logic [N-1:0]      fir_data_in_o,
  input  logic [N-1:0]      fir_data_out_i,
  output logic              out_valid_o,
  output logic [N-1:0]      out_data_o,
  output logic              busy_o,
  output logic              done_o
`ifdef FIR_SEQ_CHECKSUM_EN
  ,
  output logic [N-1:0]      checksum_o
`endif
);

  typedef enum logic [2:0] {StIdle, StFlush, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_W:0] FlushLast = (ADDR_W + 1)'(TAPS - 2);
  localparam logic [ADDR_W:0] CntOne    = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   flen_q, flen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        vld_q, vld_d;
  logic [N-1:0]      din_q, din_d;
  logic [3:0][7:0]   shadow_q, shadow_d;
  logic [3:0][7:0]   active_q, active_d;
  logic              start_ok;
  logic              abort_act;

  assign start_ok  = (state_q == StIdle) && start_i && !abort_i && (frame_len_i != '0);
  assign abort_act = abort_i && (state_q != StIdle);

  // In RUN, cnt_q counts addresses already issued; in FLUSH it counts flush cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flen_d  = flen_q;
    addr_d  = addr_q;
    if (abort_act) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_d = StFlush;
            cnt_d   = '0;
            flen_d  = frame_len_i;
          end
        end
        StFlush: begin
          if (cnt_q == FlushLast) begin
            state_d = StRun;
            cnt_d   = CntOne;
            addr_d  = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRun: begin
          if (cnt_q == flen_q) begin
            state_d = StDrain;
          end else begin
            addr_d = cnt_q[ADDR_W-1:0];
            cnt_d  = cnt_q + CntOne;
          end
        end
        // Exit once only the oldest stage remains; it retires as DONE begins.
        StDrain: begin
          if (!vld_q[0] && !vld_q[1]) state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // vld_q[0]: read in flight, [1]: sample in fir_data_in, [2]: FIR output valid.
  always_comb begin
    vld_d = abort_act ? 3'b000 : {vld_q[1:0], state_q == StRun};
    din_d = (!abort_act && vld_q[0]) ? mem_rdata_i : '0;
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (coef_we_i) shadow_d[coef_sel_i] = coef_wdata_i;
    // Commit uses pre-edge shadows, so a same-cycle write misses this frame.
    if (start_ok) active_d = shadow_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      flen_q   <= '0;
      addr_q   <= '0;
      vld_q    <= '0;
      din_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flen_q   <= flen_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      din_q    <= din_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

`ifdef FIR_SEQ_CHECKSUM_EN
  logic [N-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (vld_q[2] && !abort_act) begin
      csum_d = csum_q + fir_data_out_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`endif

  assign mem_addr_o    = addr_q;
  assign fir_b0_o      = active_q[0];
  assign fir_b1_o      = active_q[1];
  assign fir_b2_o      = active_q[2];
  assign fir_b3_o      = active_q[3];
  assign fir_data_in_o = din_q;
  assign out_valid_o   = vld_q[2];
  assign out_data_o    = fir_data_out_i;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Testbench for fir_seq_ctrl with a behavioural 4-tap FIR and sample RAM.
module tb_fir_seq_ctrl;
  localparam int N  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0;
  logic [AW:0]   frame_len = '0;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_sel = '0;
  logic [7:0]    coef_wdata = '0;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_rdata;
  logic [7:0]    b0, b1, b2, b3;
  logic [N-1:0]  fir_in, fir_out, out_data;
  logic          out_valid, busy, done;
`ifdef FIR_SEQ_CHECKSUM_EN
  logic [N-1:0]  checksum;
`endif

  fir_seq_ctrl #(.N(N), .ADDR_W(AW), .TAPS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .frame_len_i(frame_len), .coef_we_i(coef_we), .coef_sel_i(coef_sel),
    .coef_wdata_i(coef_wdata), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .fir_b0_o(b0), .fir_b1_o(b1), .fir_b2_o(b2), .fir_b3_o(b3),
    .fir_data_in_o(fir_in), .fir_data_out_i(fir_out), .out_valid_o(out_valid),
    .out_data_o(out_data), .busy_o(busy), .done_o(done)
`ifdef FIR_SEQ_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  // Sample RAM (read latency 1) and FIR delay line.
  logic [N-1:0] ram [32];
  logic [N-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    d0 <= fir_in; d1 <= d0; d2 <= d1; d3 <= d2;
  end
  assign fir_out = b0 * d0 + b1 * d1 + b2 * d2 + b3 * d3;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Per-frame observations, cycle 0 = cycle start is presented.
  int           first_v, done_cyc, done_n, busy_fall, addr_err;
  logic         busy1;
  logic [31:0]  b_at1;
  logic [N-1:0] outs[$];

  task automatic set_coefs(input logic [7:0] c0, c1, c2, c3);
    logic [7:0] c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      coef_we = 1'b1; coef_sel = 2'(i); coef_wdata = c[i];
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic fill_ram(input logic [N-1:0] val, input bit ramp);
    for (int i = 0; i < 32; i++) ram[i] = ramp ? N'(i + 1) : val;
  endtask

  task automatic launch(input logic [AW:0] flen, input logic cwe, input logic [7:0] cval,
                        input int nexp);
    outs.delete();
    first_v = -1; done_cyc = -1; done_n = 0; busy_fall = -1; addr_err = 0;
    @(posedge clk); #1;
    frame_len = flen; start = 1'b1;
    coef_we = cwe; coef_sel = 2'd0; coef_wdata = cval;
    @(posedge clk); #1;
    start = 1'b0; coef_we = 1'b0;
    for (int cyc = 1; cyc < 90; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin busy1 = busy; b_at1 = {b0, b1, b2, b3}; end
      if (cyc >= 4 && cyc < 4 + nexp && mem_addr !== AW'(cyc - 4)) addr_err++;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        outs.push_back(out_data);
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if (cyc > 1 && !busy) begin busy_fall = cyc; break; end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0]   c0, c1, c2, c3;
    logic [N-1:0] fill;
    bit           ramp;
    int           flen;
    logic [N-1:0] first, last;
    int           nval, done_at;
    logic [N-1:0] csum;
  } vec_t;

  vec_t tv[6];
  logic [N-1:0] exp_stream[8];
  int dn, vn;

  initial begin
    tv[0] = '{8'd32, 8'd32, 8'd32, 8'd32, 32'd4, 1'b0, 8, 32'd128, 32'd512, 8, 15, 32'd3328};
    tv[1] = '{8'd32, 8'd32, 8'd32, 8'd32, 32'd0, 1'b0, 4, 32'd0, 32'd0, 4, 11, 32'd0};
    tv[2] = '{8'd1, 8'd2, 8'd3, 8'd4, 32'd1, 1'b0, 2, 32'd1, 32'd3, 2, 9, 32'd4};
    tv[3] = '{8'd1, 8'd0, 8'd0, 8'd0, 32'd0, 1'b1, 32, 32'd1, 32'd32, 32, 39, 32'd528};
    tv[4] = '{8'd3, 8'd0, 8'd0, 8'd0, 32'd5, 1'b0, 1, 32'd15, 32'd15, 1, 8, 32'd15};
    tv[5] = '{8'd1, 8'd1, 8'd1, 8'd1, 32'd0, 1'b1, 6, 32'd1, 32'd18, 6, 13, 32'd52};
    exp_stream = '{32'd128, 32'd256, 32'd384, 32'd512, 32'd512, 32'd512, 32'd512, 32'd512};
    fill_ram(32'd0, 1'b0);

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_coefs", {b0, b1, b2, b3}, 0);
    chk("rst_fir_in", fir_in, 0);
`ifdef FIR_SEQ_CHECKSUM_EN
    chk("rst_csum", checksum, 0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      set_coefs(tv[i].c0, tv[i].c1, tv[i].c2, tv[i].c3);
      fill_ram(tv[i].fill, tv[i].ramp);
      launch(AW'(0) | (AW + 1)'(tv[i].flen), 1'b0, 8'd0, tv[i].flen);
      chk($sformatf("v%0d_coefs", i), b_at1, {tv[i].c0, tv[i].c1, tv[i].c2, tv[i].c3});
      chk($sformatf("v%0d_busy1", i), busy1, 1);
      chk($sformatf("v%0d_first_cyc", i), first_v, 7);
      chk($sformatf("v%0d_nvalid", i), outs.size(), tv[i].nval);
      if (outs.size() > 0) begin
        chk($sformatf("v%0d_first", i), outs[0], tv[i].first);
        chk($sformatf("v%0d_last", i), outs[outs.size() - 1], tv[i].last);
      end
      chk($sformatf("v%0d_done_cyc", i), done_cyc, tv[i].done_at);
      chk($sformatf("v%0d_done_n", i), done_n, 1);
      chk($sformatf("v%0d_busy_fall", i), busy_fall, tv[i].done_at + 1);
      chk($sformatf("v%0d_addr_err", i), addr_err, 0);
`ifdef FIR_SEQ_CHECKSUM_EN
      chk($sformatf("v%0d_csum", i), checksum, tv[i].csum);
`endif
    end

    // Full output stream of the reference frame; address holds afterwards
    set_coefs(8'd32, 8'd32, 8'd32, 8'd32);
    fill_ram(32'd4, 1'b0);
    launch(6'd8, 1'b0, 8'd0, 8);
    chk("stream_len", outs.size(), 8);
    for (int k = 0; k < 8 && k < outs.size(); k++)
      chk($sformatf("stream_%0d", k), outs[k], exp_stream[k]);
    chk("addr_hold", mem_addr, 7);

    // Coefficient write in the same cycle as start lands in shadow only
    set_coefs(8'd2, 8'd0, 8'd0, 8'd0);
    fill_ram(32'd0, 1'b0);
    ram[0] = 32'd5;
    launch(6'd4, 1'b1, 8'd1, 4);
    chk("coll_coefs", b_at1, {8'd2, 8'd0, 8'd0, 8'd0});
    chk("coll_first", outs.size() > 0 ? outs[0] : 'x, 10);
    launch(6'd4, 1'b0, 8'd0, 4);
    chk("coll_next_coefs", b_at1, {8'd1, 8'd0, 8'd0, 8'd0});
    chk("coll_next_first", outs.size() > 0 ? outs[0] : 'x, 5);

    // Zero-length frame is ignored
    launch(6'd0, 1'b0, 8'd0, 0);
    chk("len0_busy", busy1, 0);
    chk("len0_done", done_n, 0);
    chk("len0_valid", outs.size(), 0);

    // Abort in RUN while address 3 is issued
    set_coefs(8'd32, 8'd32, 8'd32, 8'd32);
    fill_ram(32'd4, 1'b0);
    @(posedge clk); #1; frame_len = 6'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_addr", mem_addr, 3);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_fir_in", fir_in, 0);
    chk("abort_coefs", {b0, b1, b2, b3}, {8'd32, 8'd32, 8'd32, 8'd32});
    dn = 0; vn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
      if (out_valid) vn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_valid", vn, 0);
    launch(6'd8, 1'b0, 8'd0, 8);
    chk("post_abort_done", done_cyc, 15);
    chk("post_abort_first", outs.size() > 0 ? outs[0] : 'x, 128);
    chk("post_abort_n", outs.size(), 8);

    // Abort and start together in idle: abort wins
    @(posedge clk); #1; frame_len = 6'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_start_busy_later", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Frame sequencer for the 4-tap parallel FIR datapath. It holds shadow and active coefficient banks, flushes the FIR delay line with zeros, and streams a frame of samples from a synchronous sample RAM into the filter. It tags each valid filter output and signals frame completion. It sits between the host/testbench control and the FIR_Filter instance, and drives that instance's b0..b3 and data_in.

Parameters:
N, 32, sample/output word width
ADDR_W, 5, sample RAM address width (frame up to 2^ADDR_W samples)
TAPS, 4, filter taps; fixed at 4, sets flush length TAPS-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  frame request pulse; honoured only in IDLE
abort  in  1  cancel current frame
frame_len  in  ADDR_W+1  sample count, valid range 1..2^ADDR_W
coef_we  in  1  coefficient shadow write strobe
coef_sel  in  2  shadow index 0..3
coef_wdata  in  8  coefficient value
mem_addr  out  ADDR_W  sample RAM read address (RAM read latency 1)
mem_rdata  in  N  sample RAM read data
fir_b0..fir_b3  out  8 each  active coefficients to FIR
fir_data_in  out  N  sample to FIR (registered)
fir_data_out  in  N  FIR output (one clk after fir_data_in)
out_valid  out  1  fir_data_out belongs to current frame
out_data  out  N  copy of fir_data_out, qualified by out_valid
busy  out  1  high from FLUSH through DONE
done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (reset=0, async): all outputs 0; shadow and active coefficients 0; FSM=IDLE.
- Shadow regs: coef_we writes shadow[coef_sel] in any state. Active regs (fir_b*) load all four shadows on the edge that accepts start.
- A write in the same cycle as an accepted start lands in shadow only. It is not part of that commit.
- FSM states: IDLE, FLUSH, RUN, DRAIN, DONE.
- IDLE: start=1 && frame_len!=0 -> FLUSH. start with frame_len==0 is ignored. start outside IDLE is ignored.
- FLUSH: TAPS-1 = 3 cycles -> RUN.
- RUN: issue mem_addr = 0,1,…,frame_len-1 on consecutive cycles, one per cycle. After the last address -> DRAIN.
- DRAIN: wait until the 3-deep valid pipeline is empty -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- fir_data_in register: loads mem_rdata the cycle after a RUN read. Otherwise loads 0, so zeros are guaranteed in FLUSH, DRAIN and IDLE.
- Timing, with start accepted at edge 0:
  - busy rises and fir_b* update at cycle 1.
  - FLUSH occupies cycles 1-3.
  - Address k is issued at cycle 4+k.
  - fir_data_in = sample k at cycle 6+k.
  - out_valid=1 with out_data = result k at cycle 7+k.
  - done pulses at cycle 7+L (L = frame_len); busy falls at cycle 8+L.
- out_data mirrors fir_data_out every cycle. Consumers must qualify it with out_valid.
- mem_addr holds its last value outside RUN.
- abort (any state except IDLE):
  - Next cycle FSM=IDLE; busy=0, out_valid=0; pending valid bits are cleared.
  - fir_data_in=0; no done pulse.
  - Active coefficients are retained.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- Arithmetic: the controller does no filtering. Counters are ADDR_W+1 bits, so frame_len = 2^ADDR_W gives addresses 0..2^ADDR_W-1 without wrap error.

Optional Feature:
FIR_SEQ_CHECKSUM_EN
- Defined: adds output checksum [N-1:0].
  - Cleared to 0 on accepted start.
  - On each out_valid cycle, adds out_data, modulo 2^N.
  - Holds after done; reset value 0.
  - abort holds the current value.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

Test Plan:
- Write shadows 32,32,32,32; RAM all 4; start with frame_len=8 -> fir_b*=32 at cycle 1; out_valid cycles 7..14 with out_data 128,256,384,512,512,512,512,512; done at 15.
- Run a frame of 4s, then RAM all 0, frame_len=4 -> outputs 0,0,0,0. This shows FLUSH cleared the delay line.
- coef_we shadow0=1 on the same cycle as start, prior shadows 2,0,0,0, RAM sample0=5 -> first out_data=10. The next frame uses b0=1.
- frame_len=0 with start -> busy stays 0, no done. frame_len=32 -> addresses 0..31, 32 out_valid cycles, done at cycle 39.
- abort in RUN at address 3 -> next cycle busy=0, out_valid=0, no done. A new start runs normally.
- FIR_SEQ_CHECKSUM_EN on, first test stimulus -> checksum=3328 after done. A second frame restarts from 0.
